spike_arbiter: RTL and testbench

- Round-robin arbiter that shares one neuron-core spike input port between NUM_CH spike sources (e.g. the four switch-driven spike channels A-D).
- Each source presents a DATA_W-bit spike value with a valid/ready handshake.
- The arbiter forwards one value per cycle through a single registered output stage, tagged with the source channel ID.
- Sits between the spike generators / FPGA test stimulus and the neuron accumulator.

---
 rtl/spike_arbiter.sv | 110 +++++++++++
 tb/tb_spike_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/spike_arbiter.sv
// Round-robin arbiter merging NUM_CH spike sources into one registered output stage.
// Optional build macro SPIKE_ARB_ZERO_DROP_EN: zero-valued beats are accepted but never forwarded.
module spike_arbiter #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 32,
  parameter int ID_W   = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic [NUM_CH-1:0]        in_valid,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  output logic [NUM_CH-1:0]        in_ready,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [ID_W-1:0]          out_id,
  output logic                     busy
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [ID_W-1:0]     ptr_q, ptr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [ID_W-1:0]     id_q, id_d;

  logic [DATA_W-1:0]   chan_data_s [NUM_CH];
  logic                load_ok_s;
  logic                found_s;
  logic [ID_W-1:0]     win_id_s;
  logic [ID_W-1:0]     cand_s;
  logic [DATA_W-1:0]   win_data_s;
  logic                xfer_s;
  logic                load_s;
  int                  idx_s;

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      chan_data_s[i] = in_data[i*DATA_W +: DATA_W];
    end
  end

  assign load_ok_s = enable & ((state_q == EMPTY) | out_ready);

  // Search starts just after the last granted channel and wraps, so channel ptr+1 has top priority.
  always_comb begin
    found_s    = 1'b0;
    win_id_s   = '0;
    win_data_s = '0;
    cand_s     = '0;
    idx_s      = 0;
    for (int k = 1; k <= NUM_CH; k++) begin
      idx_s  = (int'(ptr_q) + k) % NUM_CH;
      cand_s = ID_W'(idx_s);
      if (!found_s && in_valid[cand_s]) begin
        found_s    = 1'b1;
        win_id_s   = cand_s;
        win_data_s = chan_data_s[cand_s];
      end
    end
  end

  assign in_ready = (load_ok_s && found_s && !rst) ? (NUM_CH'(1) << win_id_s) : '0;
  assign xfer_s   = |(in_valid & in_ready);

`ifdef SPIKE_ARB_ZERO_DROP_EN
  assign load_s = xfer_s & (win_data_s != '0);
`else
  assign load_s = xfer_s;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    data_d  = data_q;
    id_d    = id_q;
    if (xfer_s) begin
      ptr_d = win_id_s;
    end
    // A load in the same cycle as a drain keeps FULL, giving back-to-back beats without a bubble.
    if (load_s) begin
      state_d = FULL;
      data_d  = win_data_s;
      id_d    = win_id_s;
    end else if (state_q == FULL && out_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      ptr_q   <= ID_W'(NUM_CH - 1);
      data_q  <= '0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      id_q    <= id_d;
    end
  end

  assign out_valid = (state_q == FULL);
  assign out_data  = data_q;
  assign out_id    = id_q;
  assign busy      = out_valid | (|in_valid);

endmodule

// File: tb/tb_spike_arbiter.sv
// Scoreboard bench for spike_arbiter: directed stimulus pushes expected beats, a monitor pops and compares.
module tb_spike_arbiter;
  localparam int NUM_CH = 4;
  localparam int DATA_W = 32;
  localparam int ID_W   = 2;

  logic                     clk;
  logic                     rst;
  logic                     enable;
  logic [NUM_CH-1:0]        in_valid;
  logic [NUM_CH*DATA_W-1:0] in_data;
  logic [NUM_CH-1:0]        in_ready;
  logic                     out_valid;
  logic                     out_ready;
  logic [DATA_W-1:0]        out_data;
  logic [ID_W-1:0]          out_id;
  logic                     busy;

  logic [DATA_W-1:0]        dat [NUM_CH];
  logic [NUM_CH-1:0]        hold;
  logic [ID_W+DATA_W-1:0]   sb_q [$];
  logic [ID_W+DATA_W-1:0]   exp_v;
  int                       grants [$];
  int                       total;
  int                       bad;

  assign in_data = {dat[3], dat[2], dat[1], dat[0]};

  spike_arbiter #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .ID_W(ID_W)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_id(out_id), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input int id, input int data);
    sb_q.push_back({ID_W'(id), DATA_W'(data)});
  endtask

  function automatic logic [63:0] pack_grants();
    logic [63:0] r;
    r = 64'd0;
    for (int i = 0; i < grants.size() && i < 16; i++) begin
      r = r | (64'(grants[i]) << (4 * i));
    end
    return r;
  endfunction

  // One clock: note which channel handshakes, then retire it unless it is held.
  task automatic cycle();
    logic [NUM_CH-1:0] rdy;
    @(negedge clk);
    rdy = in_ready & in_valid;
    @(posedge clk);
    #1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rdy[i]) begin
        grants.push_back(i);
        if (!hold[i]) in_valid[i] = 1'b0;
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("in_ready_onehot0", 64'($onehot0(in_ready)), 64'd1);
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_beat: got id=%0d data=%0d expected none", out_id, out_data);
        end else begin
          exp_v = sb_q.pop_front();
          chk("out_id", 64'(out_id), 64'(exp_v[ID_W+DATA_W-1:DATA_W]));
          chk("out_data", 64'(out_data), 64'(exp_v[DATA_W-1:0]));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0; bad = 0;
    rst = 1'b1; enable = 1'b0; in_valid = '0; out_ready = 1'b0; hold = '0;
    for (int i = 0; i < NUM_CH; i++) dat[i] = '0;

    // Reset state, with requests present to show in_ready stays low in reset
    #12;
    in_valid = 4'hF;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_id", 64'(out_id), 64'd0);
    chk("rst_busy", 64'(busy), 64'd1);
    in_valid = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("idle_busy", 64'(busy), 64'd0);

    // Test 1: all four channels, 10,1,2,5 in channel order
    dat[0] = 32'd10; dat[1] = 32'd1; dat[2] = 32'd2; dat[3] = 32'd5;
    in_valid = 4'hF; out_ready = 1'b1; enable = 1'b1;
    push(0, 10); push(1, 1); push(2, 2); push(3, 5);
    grants.delete();
    #1;
    chk("t1_first_grant", 64'(in_ready), 64'h1);
    chk("t1_no_valid_yet", 64'(out_valid), 64'd0);
    cycle();
    chk("t1_latency", 64'(out_valid), 64'd1);
    repeat (3) cycle();
    cycle();
    chk("t1_grants", pack_grants(), 64'h3210);
    chk("t1_sb_empty", 64'(sb_q.size()), 64'd0);

    // Test 2: channels 0 and 2 held valid alternate
    grants.delete();
    dat[0] = 32'd20; dat[2] = 32'd22;
    hold = 4'b0101; in_valid = 4'b0101;
    push(0, 20); push(2, 22); push(0, 20); push(2, 22);
    repeat (4) cycle();
    in_valid = '0; hold = '0;
    cycle();
    chk("t2_grants", pack_grants(), 64'h2020);
    chk("t2_sb_empty", 64'(sb_q.size()), 64'd0);

    // Test 3: stall with channel 1 still requesting
    out_ready = 1'b0;
    dat[1] = 32'd1; hold = 4'b0010; in_valid = 4'b0010;
    push(1, 1); push(1, 1);
    cycle();
    repeat (5) begin
      @(negedge clk);
      chk("t3_hold_valid", 64'(out_valid), 64'd1);
      chk("t3_hold_data", 64'(out_data), 64'd1);
      chk("t3_hold_id", 64'(out_id), 64'd1);
      chk("t3_stall_ready", 64'(in_ready), 64'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    cycle();
    in_valid = '0; hold = '0;
    cycle();
    chk("t3_sb_empty", 64'(sb_q.size()), 64'd0);

    // Test 4: enable low drains without granting; then next after ptr wins
    dat[2] = 32'd7; in_valid = 4'b0100;
    push(2, 7);
    cycle();
    enable = 1'b0;
    dat[3] = 32'd9; dat[0] = 32'd3;
    hold = 4'b1001; in_valid = 4'b1001;
    @(negedge clk);
    chk("t4_no_grant_full", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t4_drained", 64'(out_valid), 64'd0);
    chk("t4_no_grant_empty", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    enable = 1'b1;
    #1;
    chk("t4_next_grant", 64'(in_ready), 64'h8);
    push(3, 9);
    hold = '0;
    cycle();
    in_valid = '0;
    cycle();
    chk("t4_sb_empty", 64'(sb_q.size()), 64'd0);

    // Test 5: asynchronous reset discards the held beat
    dat[1] = 32'd11; dat[2] = 32'd12;
    hold = 4'b0110; in_valid = 4'b0110;
    cycle();
    #2;
    rst = 1'b1;
    #1;
    chk("t5_async_valid", 64'(out_valid), 64'd0);
    chk("t5_async_ready", 64'(in_ready), 64'd0);
    hold = '0; in_valid = '0;
    dat[0] = 32'd30; dat[1] = 32'd31; dat[2] = 32'd32;
    @(posedge clk); #1;
    rst = 1'b0;
    in_valid = 4'b0111;
    #1;
    chk("t5_ch0_first", 64'(in_ready), 64'h1);
    push(0, 30); push(1, 31); push(2, 32);
    repeat (3) cycle();
    cycle();
    chk("t5_sb_empty", 64'(sb_q.size()), 64'd0);

    // Test 6: zero-valued beats (dropped only when the option is built in)
    rst = 1'b1;
    #2;
    rst = 1'b0;
    grants.delete();
    dat[0] = 32'd0; dat[1] = 32'd1; dat[2] = 32'd0; dat[3] = 32'd5;
    in_valid = 4'hF;
`ifdef SPIKE_ARB_ZERO_DROP_EN
    push(1, 1); push(3, 5);
`else
    push(0, 0); push(1, 1); push(2, 0); push(3, 5);
`endif
    repeat (4) cycle();
    cycle();
    chk("t6_grants", pack_grants(), 64'h3210);
    chk("t6_sb_empty", 64'(sb_q.size()), 64'd0);
    chk("t6_idle", 64'(out_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
